snapshot_restore_ctrl: RTL and testbench

SNAPSHOT_RESTORE_CTRL -- requirements
Module: snapshot_restore_ctrl

---
 rtl/snapshot_restore_ctrl.sv | 116 +++++++++++
 tb/tb_snapshot_restore_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_restore_ctrl.sv
// Restore sequencer: walks N_REGS snapshot entries, fetching each bit pair and
// loading it into the matching DFFx, with abort and async reset handling.
module snapshot_restore_ctrl #(
    parameter int N_REGS = 16,
    parameter int IDX_W  = 4
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             start,
    input  logic             abort,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic             rd_data,
    input  logic             rd_valid,
    output logic             ld,
    output logic [IDX_W-1:0] sel,
    output logic             rD,
    output logic             rV,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        DONE    = 3'd3,
        ABORTED = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // idx is only advanced out of a non-final LOAD, so it can never pass LAST_IDX
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (start && !abort) w_state_nxt = FETCH;
            end
            FETCH: begin
                w_state_nxt = abort ? ABORTED : LOAD;
            end
            LOAD: begin
                if (abort) begin
                    w_state_nxt = ABORTED;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FETCH;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            ABORTED: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        ld      = 1'b0;
        sel     = '0;
        rD      = 1'b0;
        rV      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        case (r_state)
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = r_idx;
                busy    = 1'b1;
            end
            LOAD: begin
                ld   = !abort;
                sel  = r_idx;
                rD   = rd_data;
                rV   = rd_valid;
                busy = 1'b1;
            end
            DONE:    done    = 1'b1;
            ABORTED: aborted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snapshot_restore_ctrl.sv
// Table-driven bench for snapshot_restore_ctrl: an N_REGS=4 and an N_REGS=2
// instance, each fed from a small snapshot memory model.
module tb_snapshot_restore_ctrl;

    logic CK = 1'b0;
    logic RS = 1'b1;
    always #5 CK = ~CK;

    // Instance A: N_REGS=4
    logic       st_a = 0, ab_a = 0, rdd_a, rdv_a;
    logic       rd_en_a, ld_a, rD_a, rV_a, busy_a, done_a, abd_a;
    logic [1:0] rd_addr_a, sel_a;
    // Instance B: N_REGS=2
    logic       st_b = 0, ab_b = 0, rdd_b, rdv_b;
    logic       rd_en_b, ld_b, rD_b, rV_b, busy_b, done_b, abd_b;
    logic [0:0] rd_addr_b, sel_b;

    snapshot_restore_ctrl #(.N_REGS(4), .IDX_W(2)) u_a (
        .CK(CK), .RS(RS), .start(st_a), .abort(ab_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rdd_a), .rd_valid(rdv_a),
        .ld(ld_a), .sel(sel_a), .rD(rD_a), .rV(rV_a),
        .busy(busy_a), .done(done_a), .aborted(abd_a)
    );

    snapshot_restore_ctrl #(.N_REGS(2), .IDX_W(1)) u_b (
        .CK(CK), .RS(RS), .start(st_b), .abort(ab_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rdd_b), .rd_valid(rdv_b),
        .ld(ld_b), .sel(sel_b), .rD(rD_b), .rV(rV_b),
        .busy(busy_b), .done(done_b), .aborted(abd_b)
    );

    // Snapshot memories: data/valid bit i belongs to register i. Outside a read
    // the bus carries 1s, which must never reach rD/rV.
    logic [3:0] mem_d_a = 4'b1101, mem_v_a = 4'b1011;
    logic [1:0] mem_d_b = 2'b01,   mem_v_b = 2'b10;

    always @(posedge CK) begin
        if (rd_en_a) begin
            rdd_a <= mem_d_a[rd_addr_a];
            rdv_a <= mem_v_a[rd_addr_a];
        end else begin
            rdd_a <= 1'b1;
            rdv_a <= 1'b1;
        end
        if (rd_en_b) begin
            rdd_b <= mem_d_b[rd_addr_b];
            rdv_b <= mem_v_b[rd_addr_b];
        end else begin
            rdd_b <= 1'b1;
            rdv_b <= 1'b1;
        end
    end

    // Output vector layout: {rd_en, rd_addr[1:0], ld, sel[1:0], rD, rV, busy, done, aborted}
    wire [10:0] act_a = {rd_en_a, rd_addr_a, ld_a, sel_a, rD_a, rV_a, busy_a, done_a, abd_a};
    wire [10:0] act_b = {rd_en_b, 1'b0, rd_addr_b, ld_b, 1'b0, sel_b, rD_b, rV_b, busy_b, done_b, abd_b};

    localparam logic [10:0] E_IDLE = 11'b0;
    localparam logic [10:0] E_DONE = 11'b000_0000_0010;
    localparam logic [10:0] E_ABRT = 11'b000_0000_0001;

    function automatic logic [10:0] e_fetch(input logic [1:0] a);
        return {1'b1, a, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic logic [10:0] e_load(input logic [1:0] s, input logic d, input logic v,
                                           input logic l);
        return {1'b0, 2'b00, l, s, d, v, 1'b1, 1'b0, 1'b0};
    endfunction

    typedef struct {
        string       name;
        bit          dut_b;
        logic        start;
        logic        abort;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic add(input string nm, input bit b, input logic s, input logic a,
                       input logic [10:0] e);
        vec_t v;
        v.name = nm; v.dut_b = b; v.start = s; v.abort = a; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Drive one row for a cycle; the expectation goes to the scoreboard at drive
    // time and is compared at mid-cycle once the outputs have settled.
    task automatic apply(input vec_t v);
        logic [10:0] e;
        @(posedge CK);
        #1;
        st_a = v.dut_b ? 1'b0 : v.start;
        ab_a = v.dut_b ? 1'b0 : v.abort;
        st_b = v.dut_b ? v.start : 1'b0;
        ab_b = v.dut_b ? v.abort : 1'b0;
        sb.push_back(v.exp);
        @(negedge CK);
        e = sb.pop_front();
        check(v.name, v.dut_b ? act_b : act_a, e);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #1;
        check("reset_a", act_a, E_IDLE);
        check("reset_b", act_b, E_IDLE);
        @(posedge CK); @(posedge CK);
        #1 RS = 1'b0;

        // Full N=4 restore: ld on cycles 2,4,6,8, done on 9
        add("seq_c0", 0, 1, 0, E_IDLE);
        add("seq_c1", 0, 0, 0, e_fetch(0));
        add("seq_c2", 0, 0, 0, e_load(0, 1, 1, 1));
        add("seq_c3", 0, 0, 0, e_fetch(1));
        add("seq_c4", 0, 0, 0, e_load(1, 0, 1, 1));
        add("seq_c5", 0, 0, 0, e_fetch(2));
        add("seq_c6", 0, 0, 0, e_load(2, 1, 0, 1));
        add("seq_c7", 0, 0, 0, e_fetch(3));
        add("seq_c8", 0, 0, 0, e_load(3, 1, 1, 1));
        add("seq_c9", 0, 0, 0, E_DONE);
        add("seq_c10", 0, 0, 0, E_IDLE);
        // Abort during LOAD of idx 1
        add("abl_c0", 0, 1, 0, E_IDLE);
        add("abl_c1", 0, 0, 0, e_fetch(0));
        add("abl_c2", 0, 0, 0, e_load(0, 1, 1, 1));
        add("abl_c3", 0, 0, 0, e_fetch(1));
        add("abl_c4", 0, 0, 1, e_load(1, 0, 1, 0));
        add("abl_c5", 0, 0, 0, E_ABRT);
        add("abl_c6", 0, 0, 0, E_IDLE);
        add("abl_c7", 0, 0, 0, E_IDLE);
        // Abort during FETCH
        add("abf_c0", 0, 1, 0, E_IDLE);
        add("abf_c1", 0, 0, 1, e_fetch(0));
        add("abf_c2", 0, 0, 0, E_ABRT);
        add("abf_c3", 0, 0, 0, E_IDLE);
        // start and abort together in IDLE: nothing happens
        for (int i = 0; i < 10; i++) add("stab", 0, 1, 1, E_IDLE);
        add("stab_end", 0, 0, 0, E_IDLE);
        // start held every cycle; abort in DONE is ignored
        add("rep_c0", 0, 1, 0, E_IDLE);
        add("rep_c1", 0, 1, 0, e_fetch(0));
        add("rep_c2", 0, 1, 0, e_load(0, 1, 1, 1));
        add("rep_c3", 0, 1, 0, e_fetch(1));
        add("rep_c4", 0, 1, 0, e_load(1, 0, 1, 1));
        add("rep_c5", 0, 1, 0, e_fetch(2));
        add("rep_c6", 0, 1, 0, e_load(2, 1, 0, 1));
        add("rep_c7", 0, 1, 0, e_fetch(3));
        add("rep_c8", 0, 1, 0, e_load(3, 1, 1, 1));
        add("rep_c9", 0, 1, 1, E_DONE);
        add("rep_c10", 0, 0, 0, E_IDLE);
        add("rep_c11", 0, 0, 0, E_IDLE);
        // N=2 boundary: done on cycle 5
        add("n2_c0", 1, 1, 0, E_IDLE);
        add("n2_c1", 1, 0, 0, e_fetch(0));
        add("n2_c2", 1, 0, 0, e_load(0, 1, 0, 1));
        add("n2_c3", 1, 0, 0, e_fetch(1));
        add("n2_c4", 1, 0, 0, e_load(1, 0, 1, 1));
        add("n2_c5", 1, 0, 0, E_DONE);
        add("n2_c6", 1, 0, 0, E_IDLE);
        // Lead-in to the async reset case: start, then FETCH of idx 0 and 1
        add("rst_c0", 0, 1, 0, E_IDLE);
        add("rst_c1", 0, 0, 0, e_fetch(0));
        add("rst_c2", 0, 0, 0, e_load(0, 1, 1, 1));
        add("rst_c3", 0, 0, 0, e_fetch(1));
        run_table();

        // Reset lands between edges while loading idx 1
        @(posedge CK);
        #1 st_a = 0; ab_a = 0;
        check("rst_preload", act_a, e_load(1, 0, 1, 1));
        #1 RS = 1'b1;
        #1 check("rst_async", act_a, E_IDLE);
        @(posedge CK);
        #1 check("rst_hold", act_a, E_IDLE);
        @(negedge CK);
        RS = 1'b0;

        add("post_c0", 0, 0, 0, E_IDLE);
        add("post_c1", 0, 0, 0, E_IDLE);
        add("post_c2", 0, 1, 0, E_IDLE);
        add("post_c3", 0, 0, 0, e_fetch(0));
        add("post_c4", 0, 0, 0, e_load(0, 1, 1, 1));
        add("post_c5", 0, 0, 1, e_fetch(1));
        add("post_c6", 0, 0, 0, E_ABRT);
        add("post_c7", 0, 0, 0, E_IDLE);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
